// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite read responder.
//   AXI_ADDR_W / AXI_DATA_W : bus widths (64/64)
//   RESP_*                  : R_RESP encodings
//   rd_slv_state_t          : responder FSM states
//   r_beat_t                : captured R-channel payload (data + resp)
package axi4_lite_pkg;

    localparam int unsigned AXI_ADDR_W = 64;
    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_RESP_W = 2;

    typedef logic [AXI_RESP_W-1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_EXOKAY = 2'b01;
    localparam axi_resp_t RESP_SLVERR = 2'b10;
    localparam axi_resp_t RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        RESP     = 2'd2
    } rd_slv_state_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        axi_resp_t             resp;
    } r_beat_t;

    // Unsigned window test written so that base+size is never formed.
    function automatic logic addr_in_window(
        input logic [AXI_ADDR_W-1:0] addr,
        input logic [AXI_ADDR_W-1:0] base,
        input logic [AXI_ADDR_W-1:0] size
    );
        return (addr >= base) && ((addr - base) < size);
    endfunction

endpackage

// File: rtl/axi4_lite_read_slave_if.sv
// AXI4-Lite read-channel (AR/R) signal bundle.
//   master modport : drives AR_ADDR, AR_VALID, R_READY
//   slave modport  : drives AR_READY, R_DATA, R_RESP, R_VALID
interface axi4_lite_read_slave_if;
    import axi4_lite_pkg::*;

    logic [AXI_ADDR_W-1:0] AR_ADDR;
    logic                  AR_VALID;
    logic                  AR_READY;
    logic [AXI_DATA_W-1:0] R_DATA;
    axi_resp_t             R_RESP;
    logic                  R_VALID;
    logic                  R_READY;

    modport master (
        output AR_ADDR, AR_VALID, R_READY,
        input  AR_READY, R_DATA, R_RESP, R_VALID
    );

    modport slave (
        input  AR_ADDR, AR_VALID, R_READY,
        output AR_READY, R_DATA, R_RESP, R_VALID
    );

endinterface

// File: rtl/axi4_lite_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
//   CLK   : clock
//   RST_n : synchronous active-low reset, loads SEED
//   lfsr  : current LFSR state
module axi4_lite_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       CLK,
    input  logic       RST_n,
    output logic [7:0] lfsr
);

    localparam int unsigned LFSR_W = 8;

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Taps at x^8, x^6, x^5, x^4 map to bits 7, 5, 4, 3.
    always_comb begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/axi4_lite_read_slave.sv
// AXI4-Lite read responder: one outstanding AR, window decode, single-beat
// backing-store read with timeout, R beat held until accepted.
//   CLK, RST_n      : clock, synchronous active-low reset
//   axi (slave)     : AR/R channel
//   mem_req         : one-cycle read strobe, asserted in the AR handshake cycle
//   mem_addr        : 8-byte aligned offset from BASE_ADDR (0 when mem_req low)
//   mem_rvalid/rdata/err : backing-store response
// Optional build macro AXI4_LITE_READ_SLAVE_RAND_DELAY_EN adds a 0-7 cycle
// pseudo-random hold-off before R_VALID on every response.
module axi4_lite_read_slave
    import axi4_lite_pkg::*;
#(
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR   = 64'h8000_0000,
    parameter logic [AXI_ADDR_W-1:0] SIZE_BYTES  = 64'h0800_0000,
    parameter int unsigned           MEM_TIMEOUT = 255
) (
    input  logic                   CLK,
    input  logic                   RST_n,
    axi4_lite_read_slave_if.slave  axi,
    output logic                   mem_req,
    output logic [AXI_ADDR_W-1:0]  mem_addr,
    input  logic                   mem_rvalid,
    input  logic [AXI_DATA_W-1:0]  mem_rdata,
    input  logic                   mem_err
);

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned CNT_CMP_W = CNT_W + 1;

    // Elaboration-time parameter sanity.
    if (BASE_ADDR > ~SIZE_BYTES) begin : g_err_wrap
        $error("BASE_ADDR + SIZE_BYTES wraps the 64-bit address space");
    end
    if ((SIZE_BYTES == '0) || ((SIZE_BYTES & (SIZE_BYTES - 64'd1)) != '0)) begin : g_err_pow2
        $error("SIZE_BYTES must be a non-zero power of two");
    end
    if ((MEM_TIMEOUT < 1) || (MEM_TIMEOUT > 255)) begin : g_err_tmo
        $error("MEM_TIMEOUT must be in 1..255");
    end

    rd_slv_state_t         state_q, state_d;
    logic                  ar_ready_q, ar_ready_d;
    logic                  r_valid_q, r_valid_d;
    r_beat_t               r_q, r_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  ar_hs;
    logic                  in_win;
    logic                  mem_timeout;
    logic                  resp_entry;
    logic [AXI_ADDR_W-1:0] offset;

`ifdef AXI4_LITE_READ_SLAVE_RAND_DELAY_EN
    localparam int unsigned DLY_W = 3;

    logic [7:0]       lfsr;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             unused_lfsr;

    axi4_lite_lfsr8 #(.SEED(8'hA5)) u_lfsr (
        .CLK   (CLK),
        .RST_n (RST_n),
        .lfsr  (lfsr)
    );

    assign unused_lfsr = ^lfsr[7:DLY_W];
`endif

    // AR_READY is only high in IDLE; reset gating keeps mem_req quiet while in reset.
    assign ar_hs       = RST_n && (state_q == IDLE) && ar_ready_q && axi.AR_VALID;
    assign offset      = axi.AR_ADDR - BASE_ADDR;
    assign in_win      = addr_in_window(axi.AR_ADDR, BASE_ADDR, SIZE_BYTES);
    // Counter value of the current cycle plus one equals cycles spent waiting.
    assign mem_timeout = ({1'b0, cnt_q} + CNT_CMP_W'(1)) >= CNT_CMP_W'(MEM_TIMEOUT);

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        resp_entry = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
`ifdef AXI4_LITE_READ_SLAVE_RAND_DELAY_EN
        dly_d      = dly_q;
`endif

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ar_hs) begin
                    ar_ready_d = 1'b0;
                    if (in_win) begin
                        mem_req  = 1'b1;
                        mem_addr = {offset[AXI_ADDR_W-1:3], 3'b000};
                        state_d  = MEM_WAIT;
                    end else begin
                        r_d.data   = '0;
                        r_d.resp   = RESP_DECERR;
                        resp_entry = 1'b1;
                    end
                end
            end

            MEM_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response in the final wait cycle still wins over the timeout.
                if (mem_rvalid) begin
                    r_d.data   = mem_rdata;
                    r_d.resp   = mem_err ? RESP_SLVERR : RESP_OKAY;
                    resp_entry = 1'b1;
                end else if (mem_timeout) begin
                    r_d.data   = '0;
                    r_d.resp   = RESP_SLVERR;
                    resp_entry = 1'b1;
                end
            end

            RESP: begin
`ifdef AXI4_LITE_READ_SLAVE_RAND_DELAY_EN
                if (!r_valid_q) begin
                    if (dly_q <= DLY_W'(1)) begin
                        r_valid_d = 1'b1;
                    end
                    dly_d = dly_q - DLY_W'(1);
                end else
`endif
                if (r_valid_q && axi.R_READY) begin
                    r_valid_d  = 1'b0;
                    ar_ready_d = 1'b1;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d    = IDLE;
                ar_ready_d = 1'b1;
                r_valid_d  = 1'b0;
            end
        endcase

        // Common RESP entry: data already captured, decide when R_VALID rises.
        if (resp_entry) begin
            state_d = RESP;
`ifdef AXI4_LITE_READ_SLAVE_RAND_DELAY_EN
            dly_d     = lfsr[DLY_W-1:0];
            r_valid_d = (lfsr[DLY_W-1:0] == '0);
`else
            r_valid_d = 1'b1;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q    <= IDLE;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_q        <= '0;
            cnt_q      <= '0;
`ifdef AXI4_LITE_READ_SLAVE_RAND_DELAY_EN
            dly_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
`ifdef AXI4_LITE_READ_SLAVE_RAND_DELAY_EN
            dly_q      <= dly_d;
`endif
        end
    end

    assign axi.AR_READY = ar_ready_q;
    assign axi.R_VALID  = r_valid_q;
    assign axi.R_DATA   = r_q.data;
    assign axi.R_RESP   = r_q.resp;

endmodule

// File: tb/tb_axi4_lite_read_slave.sv
// Self-checking bench for axi4_lite_read_slave (default build).
module tb_axi4_lite_read_slave;
    import axi4_lite_pkg::*;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] SIZE = 64'h0800_0000;
    localparam int          TMO  = 255;
    localparam int          NV   = 10;
    localparam int          NR   = 30;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_err;

    int checks = 0;
    int failures = 0;

    axi4_lite_read_slave_if axi ();

    axi4_lite_read_slave #(
        .BASE_ADDR   (BASE),
        .SIZE_BYTES  (SIZE),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .axi        (axi),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] addr;
        int          k;      // mem_rvalid cycles after mem_req, 0 = never
        logic [63:0] rdata;
        bit          err;
        int          rr;     // R_READY delay after R_VALID, 0 = already high
        int          late;   // extra stray mem_rvalid cycle, 0 = none
    } txn_t;

    typedef struct {
        bit          req;
        logic [63:0] maddr;
        int          lat;    // cycles from AR handshake to first R_VALID
        logic [1:0]  resp;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        txn_t tx;
        exp_t ex;
        bit   hold;          // keep AR_VALID up with the next address while busy
    } vec_t;

    vec_t vecs[NV];
    txn_t rtx[NR];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: expected response straight from the address map rules.
    function automatic exp_t model(input txn_t tx);
        exp_t e;
        bit   inwin;
        inwin   = (tx.addr >= BASE) && (tx.addr < BASE + SIZE);
        e.req   = inwin;
        e.maddr = inwin ? ((tx.addr - BASE) / 64'd8) * 64'd8 : 64'd0;
        if (!inwin) begin
            e.resp = 2'b11; e.data = 64'd0; e.lat = 1;
        end else if (tx.k >= 1 && tx.k <= TMO) begin
            e.resp = tx.err ? 2'b10 : 2'b00; e.data = tx.rdata; e.lat = tx.k + 1;
        end else begin
            e.resp = 2'b10; e.data = 64'd0; e.lat = TMO + 1;
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic [63:0] addr, input int k, input logic [63:0] rdata,
                                input bit err, input int rr, input int late, input bit hold,
                                input bit req, input logic [63:0] maddr, input int lat,
                                input logic [1:0] resp, input logic [63:0] edata);
        vec_t v;
        v.tx = '{addr: addr, k: k, rdata: rdata, err: err, rr: rr, late: late};
        v.ex = '{req: req, maddr: maddr, lat: lat, resp: resp, data: edata};
        v.hold = hold;
        return v;
    endfunction

    // One full read; called and returns at a falling edge.
    task automatic run_txn(input txn_t tx, input exp_t ex, input string tag,
                           input bit hold_next, input logic [63:0] next_addr);
        int          wc, t, v_t, req_cnt;
        bit          seen, rhs, done, stable, busy_ok;
        logic        post_vld, post_rdy;
        logic [63:0] d0, maddr;
        logic [1:0]  r0;
        wc = 0;
        while (axi.AR_READY !== 1'b1 && wc < 300) begin
            @(negedge CLK);
            wc++;
        end
        check({tag, "_ar_ready"}, 64'(axi.AR_READY), 64'd1);
        if (axi.AR_READY !== 1'b1) return;
        axi.AR_ADDR  = tx.addr;
        axi.AR_VALID = 1'b1;
        axi.R_READY  = (tx.rr == 0);
        mem_rvalid   = 1'b0;
        mem_err      = 1'b0;
        mem_rdata    = {$urandom, $urandom};
        #1;
        req_cnt = (mem_req === 1'b1) ? 1 : 0;
        maddr   = mem_addr;
        t = 0; v_t = -1; seen = 0; rhs = 0; done = 0; stable = 1; busy_ok = 1;
        post_vld = 1'b1; post_rdy = 1'b0; d0 = '0; r0 = '0;
        while (!done && t < 400) begin
            @(negedge CLK);
            t++;
            if (t == 1) begin
                axi.AR_VALID = hold_next;
                axi.AR_ADDR  = hold_next ? next_addr : 64'd0;
            end
            if (rhs) begin
                post_vld = axi.R_VALID;
                post_rdy = axi.AR_READY;
                done = 1;
            end else begin
                if (axi.AR_READY !== 1'b0) busy_ok = 0;
                if (!seen && axi.R_VALID === 1'b1) begin
                    seen = 1; v_t = t; d0 = axi.R_DATA; r0 = axi.R_RESP;
                end else if (seen) begin
                    if (axi.R_VALID !== 1'b1 || axi.R_DATA !== d0 || axi.R_RESP !== r0) stable = 0;
                end
                mem_rvalid = (tx.k != 0 && t == tx.k) || (tx.late != 0 && t == tx.late);
                mem_rdata  = (tx.k != 0 && t == tx.k) ? tx.rdata : {$urandom, $urandom};
                mem_err    = (tx.k != 0 && t == tx.k) ? tx.err : 1'b1;
                axi.R_READY = (tx.rr == 0) || (seen && (t - v_t) >= tx.rr);
                if (axi.R_VALID === 1'b1 && axi.R_READY) rhs = 1;
                #1;
                if (mem_req === 1'b1) req_cnt++;
            end
        end
        mem_rvalid  = 1'b0;
        mem_err     = 1'b0;
        axi.R_READY = 1'b0;
        check({tag, "_mem_req_count"}, 64'(req_cnt), 64'(ex.req));
        if (ex.req) check({tag, "_mem_addr"}, maddr, ex.maddr);
        check({tag, "_latency"}, 64'(v_t), 64'(ex.lat));
        check({tag, "_r_resp"}, 64'(r0), 64'(ex.resp));
        check({tag, "_r_data"}, d0, ex.data);
        check({tag, "_r_stable"}, 64'(stable), 64'd1);
        check({tag, "_ar_ready_busy_low"}, 64'(busy_ok), 64'd1);
        check({tag, "_post_r_valid"}, 64'(post_vld), 64'd0);
        check({tag, "_post_ar_ready"}, 64'(post_rdy), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit any_vld;
        int sel;
        logic [63:0] edges[4];

        axi.AR_ADDR = '0; axi.AR_VALID = 1'b0; axi.R_READY = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;

        vecs[0] = mk(64'h8000_0010, 3, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, 0,
                     1, 64'h10, 4, 2'b00, 64'hDEAD_BEEF_0123_4567);
        vecs[1] = mk(64'h0000_1000, 0, 64'h0, 0, 0, 0, 0,
                     0, 64'h0, 1, 2'b11, 64'h0);
        vecs[2] = mk(64'h8000_0028, 1, 64'h1111_2222_3333_4444, 0, 5, 0, 0,
                     1, 64'h28, 2, 2'b00, 64'h1111_2222_3333_4444);
        vecs[3] = mk(64'h8000_0017, 2, 64'hA5A5_A5A5_5A5A_5A5A, 1, 1, 0, 1,
                     1, 64'h10, 3, 2'b10, 64'hA5A5_A5A5_5A5A_5A5A);
        vecs[4] = mk(64'h87FF_FFFF, 1, 64'h0123_4567_89AB_CDEF, 0, 2, 0, 0,
                     1, 64'h07FF_FFF8, 2, 2'b00, 64'h0123_4567_89AB_CDEF);
        vecs[5] = mk(64'h8800_0000, 0, 64'h0, 0, 0, 0, 0,
                     0, 64'h0, 1, 2'b11, 64'h0);
        vecs[6] = mk(64'h7FFF_FFF8, 0, 64'h0, 0, 3, 0, 0,
                     0, 64'h0, 1, 2'b11, 64'h0);
        vecs[7] = mk(64'h8000_0000, 255, 64'hCAFE_F00D_0000_0001, 0, 0, 0, 0,
                     1, 64'h0, 256, 2'b00, 64'hCAFE_F00D_0000_0001);
        vecs[8] = mk(64'h8000_0040, 0, 64'h0, 0, 20, 260, 0,
                     1, 64'h40, 256, 2'b10, 64'h0);
        vecs[9] = mk(64'hFFFF_FFFF_FFFF_FFF8, 0, 64'h0, 0, 1, 0, 0,
                     0, 64'h0, 1, 2'b11, 64'h0);

        // Reset values.
        repeat (3) @(negedge CLK);
        check("rst_ar_ready", 64'(axi.AR_READY), 64'd1);
        check("rst_r_valid", 64'(axi.R_VALID), 64'd0);
        check("rst_r_data", axi.R_DATA, 64'd0);
        check("rst_r_resp", 64'(axi.R_RESP), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        RST_n = 1'b1;

        // Directed table.
        for (int i = 0; i < NV; i++) begin
            run_txn(vecs[i].tx, vecs[i].ex, $sformatf("vec%0d", i), vecs[i].hold,
                    (i + 1 < NV) ? vecs[i + 1].tx.addr : 64'd0);
        end

        // Stray mem_rvalid while idle produces no R beat.
        mem_rvalid = 1'b1; mem_rdata = 64'h1234; mem_err = 1'b0;
        any_vld = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            mem_rvalid = 1'b0;
            if (axi.R_VALID !== 1'b0) any_vld = 1;
        end
        check("idle_stray_rvalid_no_beat", 64'(any_vld), 64'd0);

        // Reset in MEM_WAIT; the late response must be dropped.
        axi.AR_ADDR = 64'h8000_0100; axi.AR_VALID = 1'b1;
        #1;
        check("rst_seq_mem_req", 64'(mem_req), 64'd1);
        @(negedge CLK);
        axi.AR_VALID = 1'b0;
        repeat (4) @(negedge CLK);
        check("rst_seq_busy_ar_ready", 64'(axi.AR_READY), 64'd0);
        RST_n = 1'b0;
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        check("rst_seq_ar_ready_after", 64'(axi.AR_READY), 64'd1);
        mem_rvalid = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0; mem_err = 1'b0;
        any_vld = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            mem_rvalid = 1'b0;
            if (axi.R_VALID !== 1'b0) any_vld = 1;
        end
        check("rst_seq_no_r_valid", 64'(any_vld), 64'd0);
        run_txn(vecs[0].tx, vecs[0].ex, "rst_seq_next", 0, 64'd0);

        // Randomized traffic against the model.
        edges[0] = BASE; edges[1] = BASE + SIZE - 64'd1;
        edges[2] = BASE - 64'd1; edges[3] = BASE + SIZE;
        for (int i = 0; i < NR; i++) begin
            sel = $urandom_range(0, 3);
            if (sel <= 1) rtx[i].addr = BASE + ({$urandom, $urandom} % SIZE);
            else if (sel == 2) rtx[i].addr = {$urandom, $urandom};
            else rtx[i].addr = edges[$urandom_range(0, 3)];
            rtx[i].k     = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 6));
            rtx[i].rdata = {$urandom, $urandom};
            rtx[i].err   = bit'($urandom_range(0, 1));
            rtx[i].rr    = int'($urandom_range(0, 3));
            rtx[i].late  = 0;
        end
        for (int i = 0; i < NR; i++) begin
            run_txn(rtx[i], model(rtx[i]), $sformatf("rnd%0d", i),
                    (i + 1 < NR) && ($urandom_range(0, 2) == 0),
                    (i + 1 < NR) ? rtx[i + 1].addr : 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
